mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/arb_types.sv | 16 +
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/arb_types.sv
// rtl/arb_types.sv - shared word type and state encoding for the memory arbiter
package arb_types;

   typedef logic [31:0] rv32i_word;

   typedef enum logic [2:0] {
      IDLE,
      INST_BUSY,
      DATA_BUSY,
      INST_DONE,
      DATA_DONE
   } arb_state_e;

   localparam logic [3:0] MBE_ALL = 4'hF;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (inst/data) arbiter onto a single downstream memory port
import arb_types::*;

module mem_arbiter #(
   parameter logic DATA_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inst_read,
   input  rv32i_word  inst_addr,
   output rv32i_word  inst_rdata,
   output logic       inst_resp,
   input  logic       data_read,
   input  logic       data_write,
   input  rv32i_word  data_addr,
   input  rv32i_word  data_wdata,
   input  logic [3:0] data_mbe,
   output rv32i_word  data_rdata,
   output logic       data_resp,
   output logic       mem_read,
   output logic       mem_write,
   output rv32i_word  mem_addr,
   output rv32i_word  mem_wdata,
   output logic [3:0] mem_mbe,
   input  rv32i_word  mem_rdata,
   input  logic       mem_resp
);

   arb_state_e state;
   logic       last_data_grant;
   logic       skip_inst;
   logic       skip_data;
   logic       inst_pend;
   logic       data_pend;
   logic       pick_data;
   logic       pick_inst;

   // A port that just completed sits out one IDLE cycle so its requester can drop the request.
   assign inst_pend = inst_read & ~skip_inst;
   assign data_pend = (data_read | data_write) & ~skip_data;
   assign pick_data = data_pend & (~inst_pend | ~last_data_grant);
   assign pick_inst = inst_pend & ~pick_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         last_data_grant <= ~DATA_FIRST;
         skip_inst       <= 1'b0;
         skip_data       <= 1'b0;
         mem_read        <= 1'b0;
         mem_write       <= 1'b0;
         mem_addr        <= '0;
         mem_wdata       <= '0;
         mem_mbe         <= '0;
         inst_rdata      <= '0;
         inst_resp       <= 1'b0;
         data_rdata      <= '0;
         data_resp       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               skip_inst <= 1'b0;
               skip_data <= 1'b0;
               if (pick_data) begin
                  state           <= DATA_BUSY;
                  last_data_grant <= 1'b1;
                  mem_addr        <= data_addr;
                  mem_wdata       <= data_wdata;
                  mem_mbe         <= data_mbe;
                  // Simultaneous read+write is resolved as a write.
                  mem_write       <= data_write;
                  mem_read        <= data_read & ~data_write;
               end else if (pick_inst) begin
                  state           <= INST_BUSY;
                  last_data_grant <= 1'b0;
                  mem_addr        <= inst_addr;
                  mem_wdata       <= '0;
                  mem_mbe         <= MBE_ALL;
                  mem_write       <= 1'b0;
                  mem_read        <= 1'b1;
               end
            end
            INST_BUSY: begin
               if (mem_resp) begin
                  mem_read   <= 1'b0;
                  mem_write  <= 1'b0;
                  inst_rdata <= mem_rdata;
                  inst_resp  <= 1'b1;
                  state      <= INST_DONE;
               end
            end
            DATA_BUSY: begin
               if (mem_resp) begin
                  mem_read   <= 1'b0;
                  mem_write  <= 1'b0;
                  data_rdata <= mem_rdata;
                  data_resp  <= 1'b1;
                  state      <= DATA_DONE;
               end
            end
            INST_DONE: begin
               inst_resp <= 1'b0;
               skip_inst <= 1'b1;
               state     <= IDLE;
            end
            DATA_DONE: begin
               data_resp <= 1'b0;
               skip_data <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inst_read = 1'b0;
   logic [31:0] inst_addr = '0;
   logic [31:0] inst_rdata;
   logic        inst_resp;
   logic        data_read = 1'b0;
   logic        data_write = 1'b0;
   logic [31:0] data_addr = '0;
   logic [31:0] data_wdata = '0;
   logic [3:0]  data_mbe = '0;
   logic [31:0] data_rdata;
   logic        data_resp;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_mbe;
   logic [31:0] mem_rdata = '0;
   logic        mem_resp = 1'b0;

   int checks = 0;
   int failures = 0;

   mem_arbiter #(.DATA_FIRST(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .inst_read  (inst_read),
      .inst_addr  (inst_addr),
      .inst_rdata (inst_rdata),
      .inst_resp  (inst_resp),
      .data_read  (data_read),
      .data_write (data_write),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_mbe   (data_mbe),
      .data_rdata (data_rdata),
      .data_resp  (data_resp),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_mbe    (mem_mbe),
      .mem_rdata  (mem_rdata),
      .mem_resp   (mem_resp)
   );

   always #5 clk = ~clk;

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      inst_read = 1'b0; data_read = 1'b0; data_write = 1'b0; mem_resp = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if ({mem_read, mem_write, inst_resp, data_resp} !== 4'b0) begin failures++; $display("FAIL reset_ctrl got=%b want=0000", {mem_read, mem_write, inst_resp, data_resp}); end
      checks++; if ({mem_addr, mem_wdata, mem_mbe} !== 68'h0) begin failures++; $display("FAIL reset_fields got=%h want=0", {mem_addr, mem_wdata, mem_mbe}); end
      checks++; if ({inst_rdata, data_rdata} !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", {inst_rdata, data_rdata}); end
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_inst_fetch();
      inst_read = 1'b1; inst_addr = 32'h60;
      @(negedge clk);
      checks++; if (mem_read !== 1'b1) begin failures++; $display("FAIL fetch_mem_read got=%b want=1", mem_read); end
      checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL fetch_mem_write got=%b want=0", mem_write); end
      checks++; if (mem_addr !== 32'h60) begin failures++; $display("FAIL fetch_mem_addr got=%h want=00000060", mem_addr); end
      checks++; if (mem_mbe !== 4'hF) begin failures++; $display("FAIL fetch_mem_mbe got=%h want=f", mem_mbe); end
      @(negedge clk);
      checks++; if (mem_read !== 1'b1 || inst_resp !== 1'b0) begin failures++; $display("FAIL fetch_hold got=%b%b want=10", mem_read, inst_resp); end
      @(negedge clk);
      mem_resp = 1'b1; mem_rdata = 32'h0000_0013;
      @(negedge clk);
      mem_resp = 1'b0;
      checks++; if (inst_resp !== 1'b1) begin failures++; $display("FAIL fetch_resp got=%b want=1", inst_resp); end
      checks++; if (inst_rdata !== 32'h0000_0013) begin failures++; $display("FAIL fetch_rdata got=%h want=00000013", inst_rdata); end
      checks++; if ({mem_read, data_resp} !== 2'b00) begin failures++; $display("FAIL fetch_done_quiet got=%b want=00", {mem_read, data_resp}); end
      inst_read = 1'b0;
      @(negedge clk);
      checks++; if (inst_resp !== 1'b0) begin failures++; $display("FAIL fetch_resp_once got=%b want=0", inst_resp); end
      checks++; if (inst_rdata !== 32'h0000_0013) begin failures++; $display("FAIL fetch_rdata_hold got=%h want=00000013", inst_rdata); end
      @(negedge clk);
   endtask

   task automatic test_store();
      data_write = 1'b1; data_addr = 32'h100; data_wdata = 32'hDEAD_BEEF; data_mbe = 4'b0011;
      @(negedge clk);
      checks++; if ({mem_write, mem_read} !== 2'b10) begin failures++; $display("FAIL store_ctrl got=%b want=10", {mem_write, mem_read}); end
      checks++; if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF || mem_mbe !== 4'b0011) begin failures++; $display("FAIL store_fields got=%h/%h/%h want=00000100/deadbeef/3", mem_addr, mem_wdata, mem_mbe); end
      mem_resp = 1'b1; mem_rdata = 32'h0;
      @(negedge clk);
      mem_resp = 1'b0;
      checks++; if (data_resp !== 1'b1 || mem_write !== 1'b0) begin failures++; $display("FAIL store_resp got=%b%b want=10", data_resp, mem_write); end
      data_write = 1'b0;
      @(negedge clk);
      checks++; if (data_resp !== 1'b0) begin failures++; $display("FAIL store_resp_once got=%b want=0", data_resp); end
      @(negedge clk);
   endtask

   task automatic test_both_rw();
      data_read = 1'b1; data_write = 1'b1; data_addr = 32'h20; data_wdata = 32'h5; data_mbe = 4'hF;
      @(negedge clk);
      checks++; if ({mem_write, mem_read} !== 2'b10) begin failures++; $display("FAIL rw_ctrl got=%b want=10", {mem_write, mem_read}); end
      checks++; if (mem_addr !== 32'h20) begin failures++; $display("FAIL rw_addr got=%h want=00000020", mem_addr); end
      data_read = 1'b0; data_write = 1'b0;
      @(negedge clk);
      checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL rw_no_abort got=%b want=1", mem_write); end
      mem_resp = 1'b1; mem_rdata = 32'hA5A5_A5A5;
      @(negedge clk);
      mem_resp = 1'b0;
      checks++; if (data_resp !== 1'b1 || data_rdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL rw_resp got=%b/%h want=1/a5a5a5a5", data_resp, data_rdata); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_no_regrant();
      inst_read = 1'b1; inst_addr = 32'h80;
      @(negedge clk);
      mem_resp = 1'b1; mem_rdata = 32'h11;
      @(negedge clk);
      mem_resp = 1'b0;
      checks++; if (inst_resp !== 1'b1) begin failures++; $display("FAIL regrant_resp got=%b want=1", inst_resp); end
      @(negedge clk);
      @(negedge clk);
      checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL regrant_skip got=%b want=0", mem_read); end
      @(negedge clk);
      checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h80) begin failures++; $display("FAIL regrant_later got=%b/%h want=1/00000080", mem_read, mem_addr); end
      inst_read = 1'b0;
      mem_resp = 1'b1; mem_rdata = 32'h22;
      @(negedge clk);
      mem_resp = 1'b0;
      checks++; if (inst_resp !== 1'b1 || inst_rdata !== 32'h22) begin failures++; $display("FAIL regrant_resp2 got=%b/%h want=1/00000022", inst_resp, inst_rdata); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_arbitration();
      apply_reset();
      inst_addr = 32'h200; data_addr = 32'h300;
      for (int k = 0; k < 3; k++) begin
         inst_read = 1'b1; data_read = 1'b1;
         @(negedge clk);
         checks++;
         if (k == 1) begin
            if (mem_addr !== 32'h200 || mem_read !== 1'b1) begin failures++; $display("FAIL arb_grant%0d got=%b/%h want=1/00000200", k, mem_read, mem_addr); end
         end else begin
            if (mem_addr !== 32'h300 || mem_read !== 1'b1) begin failures++; $display("FAIL arb_grant%0d got=%b/%h want=1/00000300", k, mem_read, mem_addr); end
         end
         mem_resp = 1'b1; mem_rdata = 32'hD0 + k;
         @(negedge clk);
         mem_resp = 1'b0;
         checks++;
         if (k == 1) begin
            if ({inst_resp, data_resp} !== 2'b10) begin failures++; $display("FAIL arb_resp%0d got=%b want=10", k, {inst_resp, data_resp}); end
         end else begin
            if ({inst_resp, data_resp} !== 2'b01) begin failures++; $display("FAIL arb_resp%0d got=%b want=01", k, {inst_resp, data_resp}); end
         end
         inst_read = 1'b0; data_read = 1'b0;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      data_write = 1'b1; data_addr = 32'h400; data_wdata = 32'h1234_5678; data_mbe = 4'hF;
      @(negedge clk);
      checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL rstmid_busy got=%b want=1", mem_write); end
      #2 rst = 1'b0;
      #1;
      checks++; if (mem_write !== 1'b0 || data_resp !== 1'b0) begin failures++; $display("FAIL rstmid_async got=%b%b want=00", mem_write, data_resp); end
      @(negedge clk);
      rst = 1'b1; data_write = 1'b0;
      @(negedge clk);
      mem_resp = 1'b1; mem_rdata = 32'h0000_0BAD;
      @(negedge clk);
      mem_resp = 1'b0;
      checks++; if ({data_resp, inst_resp, mem_read, mem_write} !== 4'b0) begin failures++; $display("FAIL rstmid_late_resp got=%b want=0000", {data_resp, inst_resp, mem_read, mem_write}); end
      checks++; if (data_rdata !== 32'h0) begin failures++; $display("FAIL rstmid_rdata got=%h want=00000000", data_rdata); end
      @(negedge clk);
   endtask

   task automatic test_stray_resp();
      mem_resp = 1'b1; mem_rdata = 32'hCAFE;
      @(negedge clk);
      mem_resp = 1'b0;
      checks++; if ({inst_resp, data_resp, mem_read, mem_write} !== 4'b0) begin failures++; $display("FAIL stray_ctrl got=%b want=0000", {inst_resp, data_resp, mem_read, mem_write}); end
      checks++; if ({inst_rdata, data_rdata} !== 64'h0) begin failures++; $display("FAIL stray_rdata got=%h want=0", {inst_rdata, data_rdata}); end
      inst_read = 1'b1; inst_addr = 32'h44;
      @(negedge clk);
      checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h44) begin failures++; $display("FAIL stray_then_grant got=%b/%h want=1/00000044", mem_read, mem_addr); end
      mem_resp = 1'b1; mem_rdata = 32'h77;
      @(negedge clk);
      mem_resp = 1'b0;
      checks++; if (inst_resp !== 1'b1 || inst_rdata !== 32'h77) begin failures++; $display("FAIL stray_then_resp got=%b/%h want=1/00000077", inst_resp, inst_rdata); end
      inst_read = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_inst_fetch();
      test_store();
      test_both_rw();
      test_no_regrant();
      test_arbitration();
      test_reset_mid();
      test_stray_resp();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
